cr16_datapath: RTL and testbench
================================

Name: cr16_datapath

Overview:
- 16-bit multicycle CR16-style datapath: PC register, 16x16 register file, immediate extender, operand/address/writeback muxes and a 3-bit-op ALU.
- Includes an ALU-control decoder that maps opcode/opext to the ALU op.
- Sits below the controller FSM, which drives all selects and enables, and beside the unified instruction/data memory.

Parameters:
- WIDTH, 16, datapath/register/PC width.
- ALUCONT, 3, ALU op code width.
- IMM, 8, instruction immediate width.
- REGBITS, 4, register address width (2^REGBITS registers).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears PC and all registers.
- wa_s  in  1  write-address select: 0 = rsrc_addr, 1 = rdest_addr.
- pc_s  in  1  next-PC select: 0 = alu_out, 1 = Rsrc.
- alub_s  in  1  ALU B select: 0 = Rsrc, 1 = extended immediate.
- mem_s  in  1  memory-address select: 0 = PC, 1 = Rsrc.
- wd_s  in  2  write-data select: 00 = mem_out, 01 = PC, 10 = extended immediate, 11 = alu_out.
- alua_s  in  2  ALU A select: 00 = PC, 01 = 0x0000, 10 = Rdest, 11 = Rsrc.
- pcen  in  1  PC load enable.
- signext_sign  in  1  1 = sign-extend imm, 0 = zero-extend.
- regwrite  in  1  register-file write enable.
- opcode  in  4  instruction bits [15:12].
- opext  in  4  instruction bits [7:4].
- mem_out  in  WIDTH  memory read data.
- rsrc_addr  in  REGBITS  source register index.
- rdest_addr  in  REGBITS  destination register index.
- imm  in  IMM  instruction immediate.
- Rsrc  out  WIDTH  register-file read port 2 (rsrc_addr); also store data.
- mem_addr  out  WIDTH  memory address.
- alu_out  out  WIDTH  combinational ALU result.

Behaviour:
- Reset (asynchronous, active-high): PC = 0 and every register = 0, held while reset = 1. Under reset, mem_addr = 0 when mem_s = 0, and Rsrc = 0.
- Register file:
  - Read ports rd1 = R[rdest_addr] ("Rdest") and rd2 = R[rsrc_addr], both combinational.
  - Synchronous write on the rising edge when regwrite = 1.
  - Reading the register being written returns the old value until the edge.
  - No hardwired-zero register.
- PC: loads the pc_s mux output on the rising edge when pcen = 1, otherwise holds. Wraps modulo 2^WIDTH.
- Extender: imm is sign- or zero-extended to WIDTH per signext_sign.
- ALU (combinational, results truncated to WIDTH), by alucont:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 MOV: pass B.
  - 110 LSH: B[4] = 0 shifts A left by B[3:0]; B[4] = 1 shifts A logically right by (-B[4:0]).
  - 111 LUI: B[7:0] placed in bits [15:8], low byte 0.
- ALU control (combinational). If opcode = 0000 the decode key is opext, otherwise the key is opcode:
  - 0101 → ADD.
  - 1001 → SUB.
  - 1011 (CMP) → SUB.
  - 0001 → AND.
  - 0010 → OR.
  - 0011 → XOR.
  - 1101 → MOV.
  - opcode 1000 → LSH, any opext.
  - opcode 1111 → LUI.
  - All other codes → ADD, used for address/PC arithmetic.
- No internal pipelining: every output is combinational from current state and inputs.

Decomposition:
- Shared package: ALU op constants (ADD…LUI), opcode/opext encodings, WIDTH default.
- One sub-module: cr16_alu_decode (opcode, opext → alucont).
- Register file, muxes and ALU stay inline.

Test Plan:
- Reset: assert reset mid-run with pcen = 1 → PC = 0, mem_addr = 0 (mem_s = 0), Rsrc = 0 immediately, without a clock edge.
- Immediate and extension:
  - wd_s = 10, wa_s = 1, rdest_addr = 3, imm = 0xFF, signext_sign = 1, regwrite = 1, one edge → R3 = 0xFFFF.
  - Repeat with signext_sign = 0 → R3 = 0x00FF.
- Load then add:
  - wd_s = 00, mem_out = 0x0005, wa_s = 0, rsrc_addr = 1 → R1 = 5, Rsrc = 5.
  - Then ADD (opcode 0000, opext 0101, alua_s = 10, alub_s = 0, wd_s = 11, wa_s = 1, rdest_addr = 2) for 3 edges → R2 = 15.
- ALU decode:
  - opcode 0101 → ADD.
  - opcode 0000 / opext 1001 → SUB; with A = 3, B = 5 → alu_out = 0xFFFE.
  - opcode 1000, B = 0x001F → A >> 1.
- PC:
  - alua_s = 00, alub_s = 1, imm = 1, pcen = 1, pc_s = 0 for 4 edges → PC = 4.
  - imm = 0xFE signed → PC = 2 after one more edge.
  - pc_s = 1 with Rsrc = 0x0040 → PC = 0x0040.
  - pcen = 0 → PC holds.
- Link and address: wd_s = 01 → register gets current PC; mem_s = 1 → mem_addr follows Rsrc.

Source files
------------

// File: rtl/cr16_datapath_pkg.sv
// Shared definitions for the CR16-style datapath.
// Holds the ALU operation codes, the opcode/opext encodings that select them,
// and the default datapath width.
package cr16_datapath_pkg;

  localparam int WIDTH_DEF = 16;

  // ALU operation codes (alucont)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
  localparam logic [2:0] ALU_LSH = 3'b110;
  localparam logic [2:0] ALU_LUI = 3'b111;

  // Opcode / opext encodings
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_LSH   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_MOV   = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

endpackage

// File: rtl/cr16_alu_decode.sv
// ALU control decoder.
// Ports:
//   opcode  in  instruction bits [15:12]
//   opext   in  instruction bits [7:4]
//   alucont out ALU operation code
// For register-type instructions (opcode 0000) the operation comes from opext;
// otherwise it comes from opcode. Shift and LUI are recognised only on the
// opcode field. Unknown codes fall back to ADD for address/PC arithmetic.
module cr16_alu_decode
  import cr16_datapath_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] opext,
  output logic [2:0] alucont
);

  logic [3:0] key;

  assign key = (opcode == OP_RTYPE) ? opext : opcode;

  // Map the decode key to an ALU operation
  always_comb begin
    alucont = ALU_ADD;
    if (opcode == OP_LSH) begin
      alucont = ALU_LSH;
    end else if (opcode == OP_LUI) begin
      alucont = ALU_LUI;
    end else begin
      case (key)
        OP_ADD:  alucont = ALU_ADD;
        OP_SUB:  alucont = ALU_SUB;
        OP_CMP:  alucont = ALU_SUB;
        OP_AND:  alucont = ALU_AND;
        OP_OR:   alucont = ALU_OR;
        OP_XOR:  alucont = ALU_XOR;
        OP_MOV:  alucont = ALU_MOV;
        default: alucont = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/cr16_datapath.sv
// 16-bit multicycle CR16-style datapath.
// Contains the PC, a 2^REGBITS x WIDTH register file, the immediate extender,
// the operand/address/write-back muxes and the ALU. All selects and enables
// come from the controller FSM.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   wa_s, pc_s, alub_s, mem_s, wd_s, alua_s   mux selects
//   pcen, regwrite      PC / register-file write enables
//   signext_sign        1 = sign-extend imm, 0 = zero-extend
//   opcode, opext       instruction fields for ALU decode
//   mem_out             memory read data
//   rsrc_addr, rdest_addr, imm   instruction fields
//   Rsrc                register read port on rsrc_addr (store data)
//   mem_addr            memory address (PC or Rsrc)
//   alu_out             combinational ALU result
module cr16_datapath
  import cr16_datapath_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ALUCONT = 3,
  parameter int IMM     = 8,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wa_s,
  input  logic               pc_s,
  input  logic               alub_s,
  input  logic               mem_s,
  input  logic [1:0]         wd_s,
  input  logic [1:0]         alua_s,
  input  logic               pcen,
  input  logic               signext_sign,
  input  logic               regwrite,
  input  logic [3:0]         opcode,
  input  logic [3:0]         opext,
  input  logic [WIDTH-1:0]   mem_out,
  input  logic [REGBITS-1:0] rsrc_addr,
  input  logic [REGBITS-1:0] rdest_addr,
  input  logic [IMM-1:0]     imm,
  output logic [WIDTH-1:0]   Rsrc,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   alu_out
);

  logic [WIDTH-1:0]   regs [2**REGBITS];
  logic [WIDTH-1:0]   pc;
  logic [WIDTH-1:0]   pc_next;
  logic [WIDTH-1:0]   rdest;
  logic [WIDTH-1:0]   ext_imm;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [WIDTH-1:0]   wd;
  logic [REGBITS-1:0] wa;
  logic [ALUCONT-1:0] alucont;
  logic [4:0]         rsh;

  cr16_alu_decode u_decode (
    .opcode  (opcode),
    .opext   (opext),
    .alucont (alucont)
  );

  // Combinational register reads; a write lands only at the clock edge
  assign rdest = regs[rdest_addr];
  assign Rsrc  = regs[rsrc_addr];

  assign ext_imm = signext_sign ? {{(WIDTH-IMM){imm[IMM-1]}}, imm}
                                : {{(WIDTH-IMM){1'b0}}, imm};

  assign wa       = wa_s   ? rdest_addr : rsrc_addr;
  assign src_b    = alub_s ? ext_imm    : Rsrc;
  assign pc_next  = pc_s   ? Rsrc       : alu_out;
  assign mem_addr = mem_s  ? Rsrc       : pc;

  // Operand A and write-data selection
  always_comb begin
    src_a = pc;
    wd    = alu_out;
    case (alua_s)
      2'b00:   src_a = pc;
      2'b01:   src_a = '0;
      2'b10:   src_a = rdest;
      2'b11:   src_a = Rsrc;
      default: src_a = pc;
    endcase
    case (wd_s)
      2'b00:   wd = mem_out;
      2'b01:   wd = pc;
      2'b10:   wd = ext_imm;
      2'b11:   wd = alu_out;
      default: wd = alu_out;
    endcase
  end

  // ALU; a right shift is encoded as a negative 5-bit count in B[4:0]
  always_comb begin
    alu_out = '0;
    rsh     = 5'd0 - src_b[4:0];
    case (alucont)
      ALU_ADD: alu_out = src_a + src_b;
      ALU_SUB: alu_out = src_a - src_b;
      ALU_AND: alu_out = src_a & src_b;
      ALU_OR:  alu_out = src_a | src_b;
      ALU_XOR: alu_out = src_a ^ src_b;
      ALU_MOV: alu_out = src_b;
      ALU_LSH: begin
        if (src_b[4]) begin
          alu_out = src_a >> rsh;
        end else begin
          alu_out = src_a << src_b[3:0];
        end
      end
      ALU_LUI: alu_out = {{(WIDTH-8){1'b0}}, src_b[7:0]} << 8;
      default: alu_out = '0;
    endcase
  end

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (pcen) begin
      pc <= pc_next;
    end
  end

  // Register file write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**REGBITS; i++) begin
        regs[i] <= '0;
      end
    end else if (regwrite) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: tb/tb_cr16_datapath.sv
// Directed self-checking bench for cr16_datapath.
module tb_cr16_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        wa_s, pc_s, alub_s, mem_s;
  logic [1:0]  wd_s, alua_s;
  logic        pcen, signext_sign, regwrite;
  logic [3:0]  opcode, opext;
  logic [15:0] mem_out;
  logic [3:0]  rsrc_addr, rdest_addr;
  logic [7:0]  imm;
  logic [15:0] Rsrc, mem_addr, alu_out;

  int passed = 0;
  int total  = 0;

  cr16_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .wa_s         (wa_s),
    .pc_s         (pc_s),
    .alub_s       (alub_s),
    .mem_s        (mem_s),
    .wd_s         (wd_s),
    .alua_s       (alua_s),
    .pcen         (pcen),
    .signext_sign (signext_sign),
    .regwrite     (regwrite),
    .opcode       (opcode),
    .opext        (opext),
    .mem_out      (mem_out),
    .rsrc_addr    (rsrc_addr),
    .rdest_addr   (rdest_addr),
    .imm          (imm),
    .Rsrc         (Rsrc),
    .mem_addr     (mem_addr),
    .alu_out      (alu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; wa_s = 1'b0; pc_s = 1'b0; alub_s = 1'b0; mem_s = 1'b0;
    wd_s = 2'b00; alua_s = 2'b00; pcen = 1'b0; signext_sign = 1'b0;
    regwrite = 1'b0; opcode = 4'h0; opext = 4'h0; mem_out = 16'h0000;
    rsrc_addr = 4'h0; rdest_addr = 4'h0; imm = 8'h00;
    #2;
    chk("reset_mem_addr", mem_addr, 16'h0000);
    chk("reset_rsrc", Rsrc, 16'h0000);
    step();
    reset = 1'b0;

    // Sign-extended immediate into R3; old value visible before the edge
    wd_s = 2'b10; wa_s = 1'b1; rdest_addr = 4'd3; imm = 8'hFF;
    signext_sign = 1'b1; regwrite = 1'b1; rsrc_addr = 4'd3;
    #1;
    chk("r3_before_edge", Rsrc, 16'h0000);
    step();
    chk("r3_sext", Rsrc, 16'hFFFF);
    signext_sign = 1'b0;
    step();
    chk("r3_zext", Rsrc, 16'h00FF);

    // Load from memory into R1
    wd_s = 2'b00; mem_out = 16'h0005; wa_s = 1'b0; rsrc_addr = 4'd1;
    step();
    chk("r1_load", Rsrc, 16'h0005);

    // R2 += R1 three times
    opcode = 4'b0000; opext = 4'b0101; alua_s = 2'b10; alub_s = 1'b0;
    wd_s = 2'b11; wa_s = 1'b1; rdest_addr = 4'd2;
    step(); step(); step();
    regwrite = 1'b0;
    #1;
    chk("add_alu_next", alu_out, 16'd20);
    rsrc_addr = 4'd2;
    #1;
    chk("r2_add", Rsrc, 16'd15);

    // Setup: R4 = 3, R5 = 0x0040, R6 = 0xFFFF
    regwrite = 1'b1; wd_s = 2'b10; wa_s = 1'b1;
    rdest_addr = 4'd4; imm = 8'h03; signext_sign = 1'b0;
    step();
    rdest_addr = 4'd5; imm = 8'h40;
    step();
    rdest_addr = 4'd6; imm = 8'hFF; signext_sign = 1'b1;
    step();
    regwrite = 1'b0;

    // ALU decode with A = R4 = 3, B = R1 = 5
    alua_s = 2'b10; rdest_addr = 4'd4; alub_s = 1'b0; rsrc_addr = 4'd1;
    opcode = 4'b0101; opext = 4'b0000; #1; chk("dec_add_opcode", alu_out, 16'h0008);
    opcode = 4'b0000; opext = 4'b1001; #1; chk("dec_sub", alu_out, 16'hFFFE);
    opext = 4'b1011; #1; chk("dec_cmp", alu_out, 16'hFFFE);
    opext = 4'b0001; #1; chk("dec_and", alu_out, 16'h0001);
    opext = 4'b0010; #1; chk("dec_or", alu_out, 16'h0007);
    opext = 4'b0011; #1; chk("dec_xor", alu_out, 16'h0006);
    opext = 4'b1101; #1; chk("dec_mov", alu_out, 16'h0005);
    opext = 4'b1111; #1; chk("dec_default_add", alu_out, 16'h0008);
    opcode = 4'b1111; opext = 4'b0000; #1; chk("dec_lui", alu_out, 16'h0500);
    opcode = 4'b1000; alub_s = 1'b1; signext_sign = 1'b0; imm = 8'h1F;
    #1; chk("lsh_right1", alu_out, 16'h0001);
    imm = 8'h02; #1; chk("lsh_left2", alu_out, 16'h000C);
    opcode = 4'b0100; #1; chk("dec_other_add", alu_out, 16'h0005);

    // PC increments
    step();
    opcode = 4'b0000; opext = 4'b0000; alua_s = 2'b00; alub_s = 1'b1;
    imm = 8'h01; signext_sign = 1'b1; pcen = 1'b1; pc_s = 1'b0; mem_s = 1'b0;
    step(); step(); step(); step();
    chk("pc_inc4", mem_addr, 16'h0004);
    imm = 8'hFE;
    step();
    chk("pc_minus2", mem_addr, 16'h0002);
    pc_s = 1'b1; rsrc_addr = 4'd5;
    step();
    chk("pc_from_rsrc", mem_addr, 16'h0040);
    pcen = 1'b0; pc_s = 1'b0;
    step(); step();
    chk("pc_hold", mem_addr, 16'h0040);

    // Link: R7 = PC, then memory address from Rsrc
    regwrite = 1'b1; wd_s = 2'b01; wa_s = 1'b1; rdest_addr = 4'd7;
    step();
    regwrite = 1'b0; rsrc_addr = 4'd7;
    #1;
    chk("link_r7", Rsrc, 16'h0040);
    mem_s = 1'b1; rsrc_addr = 4'd1;
    #1;
    chk("mem_addr_rsrc", mem_addr, 16'h0005);

    // PC wrap: load 0xFFFF then add 1
    mem_s = 1'b0; pcen = 1'b1; pc_s = 1'b1; rsrc_addr = 4'd6;
    step();
    chk("pc_ffff", mem_addr, 16'hFFFF);
    pc_s = 1'b0; imm = 8'h01;
    step();
    chk("pc_wrap", mem_addr, 16'h0000);
    step();
    chk("pc_after_wrap", mem_addr, 16'h0001);

    // Asynchronous reset mid-run with pcen still asserted
    rsrc_addr = 4'd7;
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_pc", mem_addr, 16'h0000);
    chk("async_rst_rsrc", Rsrc, 16'h0000);
    step();
    chk("rst_held_pc", mem_addr, 16'h0000);
    rsrc_addr = 4'd2;
    #1;
    chk("rst_held_r2", Rsrc, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
